// File: rtl/alu_seq_controller.sv
// alu_seq_controller: operator-stepped ALU sequencer.
// A shared entry bus is captured into A, B, carry-in and opcode on successive
// rising edges of advance_signal. A one-cycle EXEC state registers the ALU
// result, then SHOW holds it until the next step event.
module alu_seq_controller #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          ACCUM_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset_signal,
    input  logic [WIDTH-1:0] in,
    input  logic             advance_signal,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             err,
    output logic             result_valid,
    output logic [7:0]       out_control_display
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_CIN,
        S_LOAD_OP,
        S_EXEC,
        S_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [3:0]       op_q, op_d;
    logic             adv_q, adv_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             step;
    logic [3:0]       in_op;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

    // Opcode is the low nibble of the bus; narrow buses are zero-extended.
    generate
        if (WIDTH >= 4) begin : g_op_wide
            assign in_op = in[3:0];
        end else begin : g_op_narrow
            assign in_op = {{(4 - WIDTH){1'b0}}, in};
        end
    endgenerate

    // armed_q blocks a step until advance_signal has been seen low after
    // reset, so a level already high at reset release does not count.
    assign step = advance_signal & ~adv_q & armed_q;

    // ALU datapath: one extra bit on add/sub gives carry and borrow directly.
    always_comb begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff_w   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
        alu_out  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (op_q)
            4'd0: begin
                alu_out  = sum_w[MSB:0];
                alu_cout = sum_w[WIDTH];
                alu_ovf  = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
            end
            4'd1: begin
                alu_out  = diff_w[MSB:0];
                alu_cout = diff_w[WIDTH];
                alu_ovf  = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
            end
            4'd2: alu_out = a_q & b_q;
            4'd3: alu_out = a_q | b_q;
            4'd4: alu_out = a_q ^ b_q;
            4'd5: alu_out = ~a_q;
            4'd6: begin
                alu_out  = {a_q[MSB-1:0], 1'b0};
                alu_cout = a_q[MSB];
            end
            4'd7: begin
                alu_out  = {1'b0, a_q[MSB:1]};
                alu_cout = a_q[0];
            end
            4'd8:    alu_out = b_q;
            default: alu_err = 1'b1;
        endcase
    end

    // Next-state and capture logic; everything holds unless stepped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        op_d    = op_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        adv_d   = advance_signal;
        armed_d = armed_q | ~advance_signal;
        case (state_q)
            S_LOAD_A: if (step) begin
                a_d     = in;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: if (step) begin
                b_d     = in;
                state_d = S_LOAD_CIN;
            end
            S_LOAD_CIN: if (step) begin
                cin_d   = in[0];
                state_d = S_LOAD_OP;
            end
            S_LOAD_OP: if (step) begin
                op_d    = in_op;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                out_d   = alu_out;
                cout_d  = alu_cout;
                ovf_d   = alu_ovf;
                err_d   = alu_err;
                state_d = S_SHOW;
            end
            S_SHOW: if (step) begin
                if (ACCUM_EN) begin
                    a_d     = out_q;
                    state_d = S_LOAD_B;
                end else begin
                    state_d = S_LOAD_A;
                end
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_signal) begin
        if (!reset_signal) begin
            state_q <= S_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            op_q    <= 4'd0;
            adv_q   <= 1'b0;
            armed_q <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            op_q    <= op_d;
            adv_q   <= adv_d;
            armed_q <= armed_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Output mapping: results straight from flops, display one-hot from state.
    always_comb begin
        out                    = out_q;
        cout                   = cout_q;
        ovf                    = ovf_q;
        err                    = err_q;
        result_valid           = (state_q == S_SHOW);
        out_control_display    = 8'h00;
        out_control_display[0] = (state_q == S_LOAD_A);
        out_control_display[1] = (state_q == S_LOAD_B);
        out_control_display[2] = (state_q == S_LOAD_CIN);
        out_control_display[3] = (state_q == S_LOAD_OP);
        out_control_display[4] = (state_q == S_EXEC);
        out_control_display[5] = (state_q == S_SHOW);
        out_control_display[6] = ACCUM_EN;
        out_control_display[7] = err_q;
    end

endmodule

// File: tb/tb_alu_seq_controller.sv
// Bench for alu_seq_controller: a WIDTH=4 non-accumulating instance and a
// WIDTH=8 accumulating instance, each with its own result scoreboard.
module tb_alu_seq_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, adv0, cout0, ovf0, err0, rv0;
    logic [3:0] in0, out0;
    logic [7:0] disp0;
    logic       rst1_n, adv1, cout1, ovf1, err1, rv1;
    logic [7:0] in1, out1;
    logic [7:0] disp1;

    alu_seq_controller #(.WIDTH(4), .ACCUM_EN(1'b0)) u_dut0 (
        .clk(clk), .reset_signal(rst0_n), .in(in0), .advance_signal(adv0),
        .out(out0), .cout(cout0), .ovf(ovf0), .err(err0),
        .result_valid(rv0), .out_control_display(disp0)
    );

    alu_seq_controller #(.WIDTH(8), .ACCUM_EN(1'b1)) u_dut1 (
        .clk(clk), .reset_signal(rst1_n), .in(in1), .advance_signal(adv1),
        .out(out1), .cout(cout1), .ovf(ovf1), .err(err1),
        .result_valid(rv1), .out_control_display(disp1)
    );

    typedef struct {
        int unsigned out;
        bit          cout;
        bit          ovf;
        bit          err;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    res_t e0, e1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   acc1   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions, using plain integers.
    function automatic res_t model(input int w, input int a, input int b, input int c, input int op);
        res_t r;
        int mask, half, sa, sb, sr, s;
        r    = '{out: 0, cout: 1'b0, ovf: 1'b0, err: 1'b0};
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa   = (a >= half) ? a - (1 << w) : a;
        sb   = (b >= half) ? b - (1 << w) : b;
        case (op)
            0: begin
                s = a + b + c; r.out = s & mask; r.cout = (s > mask);
                sr = sa + sb + c; r.ovf = (sr >= half) || (sr < -half);
            end
            1: begin
                s = a - b - c; r.out = s & mask; r.cout = (a < b + c);
                sr = sa - sb - c; r.ovf = (sr >= half) || (sr < -half);
            end
            2: r.out = a & b;
            3: r.out = a | b;
            4: r.out = a ^ b;
            5: r.out = (~a) & mask;
            6: begin r.out = (a * 2) & mask; r.cout = (a >= half); end
            7: begin r.out = a / 2; r.cout = ((a % 2) == 1); end
            8: r.out = b;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Scoreboard monitors: compare on each rising edge of result_valid.
    logic rv0_d = 1'b0, rv1_d = 1'b0;
    always @(negedge clk) begin
        if (rv0 && !rv0_d) begin
            chk("dut0 sb has entry", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("dut0 out", 32'(out0), e0.out);
                chk("dut0 cout", 32'(cout0), 32'(e0.cout));
                chk("dut0 ovf", 32'(ovf0), 32'(e0.ovf));
                chk("dut0 err", 32'(err0), 32'(e0.err));
                chk("dut0 display", 32'(disp0), 32'(8'h20 | {e0.err, 7'b0}));
            end
        end
        rv0_d <= rv0;
    end

    always @(negedge clk) begin
        if (rv1 && !rv1_d) begin
            chk("dut1 sb has entry", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("dut1 out", 32'(out1), e1.out);
                chk("dut1 cout", 32'(cout1), 32'(e1.cout));
                chk("dut1 ovf", 32'(ovf1), 32'(e1.ovf));
                chk("dut1 err", 32'(err1), 32'(e1.err));
                chk("dut1 display", 32'(disp1), 32'(8'h60 | {e1.err, 7'b0}));
            end
        end
        rv1_d <= rv1;
    end

    // One advance pulse: high across one rising edge, then low.
    task automatic step0(input logic [3:0] v);
        @(negedge clk); in0 = v; adv0 = 1'b1;
        @(negedge clk); adv0 = 1'b0; in0 = 4'($urandom);
    endtask

    task automatic step1(input logic [7:0] v);
        @(negedge clk); in1 = v; adv1 = 1'b1;
        @(negedge clk); adv1 = 1'b0; in1 = 8'($urandom);
    endtask

    task automatic txn0(input int a, input int b, input int c, input int op);
        res_t r;
        r = model(4, a, b, c, op);
        step0(4'(a));
        step0(4'(b));
        step0({3'($urandom), c[0]});
        q0.push_back(r);
        step0(4'(op));
        repeat (3) @(negedge clk);
        chk("dut0 show holds", 32'(rv0), 32'd1);
        step0(4'($urandom));
        chk("dut0 leave to LOAD_A", 32'(disp0), 32'(8'h01 | {r.err, 7'b0}));
        chk("dut0 valid drops", 32'(rv0), 32'd0);
        chk("dut0 out held", 32'(out0), r.out);
    endtask

    task automatic txn1(input bit first, input int a, input int b, input int c, input int op);
        res_t r;
        r = model(8, first ? a : acc1, b, c, op);
        if (first) step1(8'(a));
        step1(8'(b));
        step1({7'($urandom), c[0]});
        q1.push_back(r);
        step1({4'($urandom), 4'(op)});
        repeat (2) @(negedge clk);
        chk("dut1 show holds", 32'(rv1), 32'd1);
        step1(8'($urandom));
        chk("dut1 leave to LOAD_B", 32'(disp1), 32'(8'h42 | {r.err, 7'b0}));
        chk("dut1 out held", 32'(out1), r.out);
        acc1 = int'(r.out);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, " disp"}, 32'(disp0), 32'h01);
        chk({tag, " out"}, 32'(out0), 32'd0);
        chk({tag, " flags"}, {29'd0, cout0, ovf0, err0}, 32'd0);
        chk({tag, " valid"}, 32'(rv0), 32'd0);
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        adv0 = 1'b0; adv1 = 1'b0; in0 = '0; in1 = '0;
        repeat (2) @(negedge clk);
        chk_reset0("dut0 reset");
        chk("dut1 reset disp", 32'(disp1), 32'h41);
        chk("dut1 reset out", 32'(out1), 32'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases for the 4-bit instance.
        txn0(15, 1, 1, 0);
        txn0(7, 1, 0, 0);
        txn0(0, 1, 0, 1);
        txn0(3, 5, 0, 12);
        txn0(3, 5, 0, 2);
        txn0(8, 0, 1, 1);
        txn0(9, 0, 0, 6);
        txn0(9, 0, 0, 7);

        // Long advance level in LOAD_B gives exactly one capture.
        step0(4'd6);
        @(negedge clk); in0 = 4'd9; adv0 = 1'b1;
        repeat (10) @(negedge clk);
        adv0 = 1'b0;
        chk("dut0 held adv one step", 32'(disp0), 32'h04);
        step0(4'd1);
        q0.push_back(model(4, 6, 9, 1, 0));
        // Advance kept high straight through EXEC must not leave SHOW.
        @(negedge clk); in0 = 4'd0; adv0 = 1'b1;
        repeat (4) @(negedge clk);
        adv0 = 1'b0;
        chk("dut0 adv through exec", 32'(disp0), 32'h20);
        step0(4'd0);
        chk("dut0 leave after hold", 32'(disp0), 32'h01);

        // Reset in LOAD_OP after a nonzero result, released with advance high.
        txn0(5, 6, 0, 0);
        step0(4'd2); step0(4'd3); step0(4'd1);
        chk("dut0 in LOAD_OP", 32'(disp0), 32'h08);
        @(negedge clk); rst0_n = 1'b0; adv0 = 1'b1;
        #1;
        chk_reset0("dut0 reset in LOAD_OP");
        @(negedge clk); rst0_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("dut0 no step after release", 32'(disp0), 32'h01);
        adv0 = 1'b0;
        @(negedge clk);
        txn0(10, 3, 1, 1);

        // Reset during EXEC abandons the operation.
        step0(4'd4); step0(4'd4); step0(4'd0);
        step0(4'd0);
        chk("dut0 in EXEC", 32'(disp0), 32'h10);
        rst0_n = 1'b0;
        #1;
        chk_reset0("dut0 reset in EXEC");
        @(negedge clk); rst0_n = 1'b1;
        @(negedge clk);
        txn0(2, 2, 0, 0);

        for (int i = 0; i < 40; i++)
            txn0(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));

        // Accumulating 8-bit instance.
        txn1(1'b1, 5, 3, 0, 0);
        txn1(1'b0, 0, 3, 0, 0);
        txn1(1'b0, 0, 8'hF0, 1, 0);
        txn1(1'b0, 0, 8'h80, 0, 1);
        for (int i = 0; i < 25; i++)
            txn1(1'b0, 0, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 9)));

        repeat (4) @(negedge clk);
        chk("dut0 sb drained", 32'(q0.size()), 32'd0);
        chk("dut1 sb drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
